// File: rtl/fifo_serializer_pkg.sv
// Shared constants, state encoding and parameter legality check for the FIFO read-side serializer.
package fifo_serializer_pkg;

   localparam int WORD_WIDTH      = 24;
   localparam int FIFO_DEPTH      = 32;
   localparam int CLK_DIV_DEFAULT = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_POP   = 2'd1,
      ST_SHIFT = 2'd2
   } state_e;

   // The bit clock is split into equal low/high halves, so the divider must be even.
   function automatic bit clk_div_ok(input int div);
      return (div >= 2) && ((div % 2) == 0);
   endfunction

endpackage

// File: rtl/fifo_serializer_bit_timer.sv
// Per-bit timing: CLK_DIV divider, bit counter, registered serial_clock and bit_end/last_bit strobes.
// load restarts a word at bit WORD_WIDTH-1; counting advances only while active.
module serial_bit_timer #(
   parameter int WORD_WIDTH = 24,
   parameter int CLK_DIV    = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic load,
   input  logic active,
   output logic serial_clock,
   output logic bit_end,
   output logic last_bit,
   output logic first_bit
);

   localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int CNT_W = (WORD_WIDTH > 2) ? $clog2(WORD_WIDTH) : 1;

   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sclk_q, sclk_d;

   assign bit_end      = active && (div_q == DIV_W'(CLK_DIV - 1));
   assign last_bit     = bit_end && (cnt_q == '0);
   assign first_bit    = (cnt_q == CNT_W'(WORD_WIDTH - 1));
   assign serial_clock = sclk_q;

   always_comb begin
      div_d = div_q;
      cnt_d = cnt_q;
      if (load) begin
         div_d = '0;
         cnt_d = CNT_W'(WORD_WIDTH - 1);
      end else if (active) begin
         if (div_q == DIV_W'(CLK_DIV - 1)) begin
            div_d = '0;
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
         end else begin
            div_d = div_q + 1'b1;
         end
      end
      // Registered so serial_clock is glitch-free; low half of each bit comes first.
      sclk_d = active && (div_d >= DIV_W'(CLK_DIV / 2));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         div_q  <= '0;
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

endmodule

// File: rtl/fifo_serializer.sv
// Pops 24-bit words from a FWFT FIFO and shifts them out MSB-first with bit clock and frame marker.
// First bit two cycles after enable/non-empty is seen in IDLE; a pop colliding with a FIFO write is retried.
module fifo_serializer #(
   parameter int WORD_WIDTH = fifo_serializer_pkg::WORD_WIDTH,
   parameter int CLK_DIV    = fifo_serializer_pkg::CLK_DIV_DEFAULT
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [WORD_WIDTH-1:0] fifo_data,
   input  logic                  fifo_empty,
   input  logic                  fifo_write,
   output logic                  fifo_read,
   output logic                  serial_clock,
   output logic                  serial_data,
   output logic                  frame,
   output logic                  busy
);

   import fifo_serializer_pkg::*;

   if (!clk_div_ok(CLK_DIV)) begin : g_bad_clk_div
      $error("fifo_serializer: CLK_DIV must be even and >= 2");
   end

   state_e                state_q, state_d;
   logic [WORD_WIDTH-1:0] shift_q, shift_d;
   logic                  bit_end, last_bit, first_bit;
   logic                  shifting;

   assign shifting = (state_q == ST_SHIFT);

   serial_bit_timer #(
      .WORD_WIDTH (WORD_WIDTH),
      .CLK_DIV    (CLK_DIV)
   ) u_bit_timer (
      .clock        (clock),
      .reset        (reset),
      .load         (fifo_read),
      .active       (shifting),
      .serial_clock (serial_clock),
      .bit_end      (bit_end),
      .last_bit     (last_bit),
      .first_bit    (first_bit)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      // The FIFO drops reads that coincide with a write, so hold off and retry instead.
      fifo_read = (state_q == ST_POP) && !fifo_write && !fifo_empty;
      unique case (state_q)
         ST_IDLE: begin
            if (enable && !fifo_empty) state_d = ST_POP;
         end
         ST_POP: begin
            if (fifo_read) begin
               shift_d = fifo_data;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (bit_end) shift_d = {shift_q[WORD_WIDTH-2:0], 1'b0};
            if (last_bit) state_d = (enable && !fifo_empty) ? ST_POP : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
      end
   end

   assign serial_data = shifting && shift_q[WORD_WIDTH-1];
   assign frame       = shifting && first_bit;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: doc/fifo_serializer.md
Name: fifo_serializer

Overview:
- Parallel-to-serial transmitter on the read side of the 32 x 24-bit FIFO buffer.
- Pops one 24-bit word at a time, then shifts it out MSB-first on serial_data, with a generated serial_clock and a frame marker on the first bit.
- Counterpart of the serial-to-parallel input path. Sits between the FIFO read port and the off-chip serial link.

Parameters:
- WORD_WIDTH, 24, bits per word; must match the FIFO word width.
- CLK_DIV, 4, clock cycles per serial bit; even, >= 2.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  allows new words to be started.
- fifo_data  input  WORD_WIDTH  FIFO data_out; first-word-fall-through, valid whenever fifo_empty=0.
- fifo_empty  input  1  FIFO empty flag.
- fifo_write  input  1  copy of the FIFO write_data strobe. The FIFO ignores a read in any cycle where a write is present.
- fifo_read  output  1  one-cycle pop strobe to the FIFO read_data input.
- serial_clock  output  1  bit clock; low for the first CLK_DIV/2 cycles of each bit, high for the rest.
- serial_data  output  1  current bit; changes only at bit start (serial_clock low).
- frame  output  1  high for the whole MSB bit period of each word.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: state=IDLE, shift register=0, bit counter=0, divider=0. All outputs are 0 in the cycle after reset is sampled.
- Reset mid-word aborts the word immediately (the popped word is lost) and returns to IDLE.
- States: IDLE, POP, SHIFT.
- IDLE: all serial outputs 0. If enable=1 and fifo_empty=0, next state is POP.
- POP:
  - fifo_read = ~fifo_write & ~fifo_empty (combinational from state).
  - When fifo_read=1: shift register <= fifo_data, bit counter <= WORD_WIDTH-1, divider <= 0, next state is SHIFT.
  - Otherwise stay in POP and retry next cycle. No pop is ever lost or duplicated when it collides with a FIFO write.
- SHIFT:
  - serial_data = shift register MSB.
  - frame = 1 while bit counter = WORD_WIDTH-1.
  - serial_clock is a flop output: high while divider >= CLK_DIV/2.
  - Divider counts 0..CLK_DIV-1. When it wraps, the shift register shifts left by one, zero-filled, and the bit counter decrements.
  - At divider=CLK_DIV-1 with bit counter=0 (end of the last bit): go to POP if enable=1 and fifo_empty=0, else go to IDLE.
- fifo_read is asserted only in POP. It is never high for two consecutive cycles.
- Latency: IDLE detects the condition in cycle n; fifo_read=1 in cycle n+1; MSB on serial_data with frame=1 from cycle n+2.
- Word duration is WORD_WIDTH*CLK_DIV cycles. The minimum inter-word gap is 1 cycle (POP), with serial_clock=0 and serial_data=0 during the gap.
- enable deasserted mid-word: the current word completes fully, then the block returns to IDLE.
- FIFO full or wrap-around needs no special handling; the FIFO owns its pointers.
- No underflow: a pop is never issued while fifo_empty=1.

Decomposition:
- Shared package holds WORD_WIDTH (24), FIFO depth (32), the state encoding (IDLE/POP/SHIFT) and the CLK_DIV legality check.
- One sub-module: serial_bit_timer. It holds the CLK_DIV divider and provides the registered serial_clock plus bit_end and last_bit strobes.

Test Plan:
- Single word, CLK_DIV=4: FIFO holds 24'hA5C3F0, enable=1.
  - One fifo_read pulse.
  - serial_data bit sequence 1010_0101_1100_0011_1111_0000.
  - frame high for cycles 0-3 of the word only; 96-cycle word.
  - busy drops 1 cycle after the last bit.
- Back-to-back: 3 words 24'h000001, 24'h800000, 24'hFFFFFF.
  - Exactly 3 fifo_read pulses, each separated by 97 cycles.
  - 1-cycle gap between words; frame rises 3 times.
- Pop/write collision: fifo_write=1 in the first POP cycle.
  - fifo_read=0 that cycle, =1 the next cycle.
  - Word is sent once, not duplicated; the FIFO read pointer advances by exactly 1.
- Empty/enable gating:
  - fifo_empty=1 with enable=1 gives no fifo_read and busy stays 0.
  - enable=0 with 2 words queued gives no activity.
  - enable dropped mid-word: the word completes, no second pop.
- Reset mid-word: reset asserted at bit 10 of 24'h123456.
  - Next cycle all outputs are 0 and state is IDLE.
  - After release with the FIFO still non-empty, the next word starts normally with frame=1.
